oam_sprite_selector: RTL



---
 rtl/oam_sprite_selector.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/oam_sprite_selector.sv
// OAM scan for one scanline: walks OAM Y/X pairs, hit-tests them against LY and fills a line buffer.
// Optional OAM_SCAN_XSORT_EN keeps the buffer sorted by ascending X (ties stay in OAM order).
module oam_sprite_selector #(
  parameter int unsigned NUM_SPRITES  = 40,
  parameter int unsigned BUFFER_MAX   = 10,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int unsigned T_PER_SPRITE = 2,
  localparam int unsigned NW = $clog2(BUFFER_MAX + 1),
  localparam int unsigned RW = (BUFFER_MAX > 1) ? $clog2(BUFFER_MAX) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          tclk_in,
  input  logic          start_in,
  input  logic [7:0]    LY_in,
  input  logic          tall_sprite_mode_in,
  output logic [15:0]   oam_addr_out,
  output logic          oam_addr_valid_out,
  input  logic [7:0]    oam_data_in,
  input  logic          oam_data_valid_in,
  output logic          busy_out,
  output logic          done_out,
  output logic [NW-1:0] n_sprites_out,
  output logic          overflow_out,
  input  logic [RW-1:0] rd_idx_in,
  output logic [17:0]   rd_entry_out,
  output logic          rd_valid_out
);

  localparam int unsigned EW = 18;

  if (T_PER_SPRITE != 2) begin : g_bad_t_per_sprite
    $error("oam_sprite_selector: T_PER_SPRITE must be 2");
  end
  if (NUM_SPRITES < 1 || NUM_SPRITES > 64) begin : g_bad_num_sprites
    $error("oam_sprite_selector: NUM_SPRITES must be 1..64");
  end
  if (BUFFER_MAX < 1 || BUFFER_MAX > 16) begin : g_bad_buffer_max
    $error("oam_sprite_selector: BUFFER_MAX must be 1..16");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ_Y = 2'd1,
    ST_REQ_X = 2'd2,
    ST_EVAL  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [7:0]      ly_q, ly_d;
  logic            tall_q, tall_d;
  logic [7:0]      y_q, y_d;
  logic            y_ok_q, y_ok_d;
  logic [NW-1:0]   n_q, n_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     addr_q, addr_d;
  logic            addr_valid_q, addr_valid_d;
  logic [EW-1:0]   line_q [BUFFER_MAX];
  logic [EW-1:0]   line_d [BUFFER_MAX];

  logic [8:0]      l_c;
  logic [8:0]      y9_c;
  logic [8:0]      h_c;
  logic            hit_c;
  logic [3:0]      row_c;
  logic [EW-1:0]   new_entry_c;
  logic [NW-1:0]   ins_pos_c;
  logic            last_c;
  logic [5:0]      idx_nxt_c;

  // Scanline hit test in 9 bits so Y + height never wraps.
  always_comb begin
    l_c         = 9'(ly_q) + 9'd16;
    y9_c        = 9'(y_q);
    h_c         = tall_q ? 9'd16 : 9'd8;
    hit_c       = y_ok_q && oam_data_valid_in && (y9_c <= l_c) && (l_c < y9_c + h_c);
    row_c       = 4'(l_c - y9_c);
    new_entry_c = {oam_data_in, idx_q, row_c};
    last_c      = (idx_q == 6'(NUM_SPRITES - 1));
    idx_nxt_c   = idx_q + 6'd1;
  end

  // Slot the new hit lands in: after every stored entry with X <= new X, or at the tail.
  always_comb begin
    ins_pos_c = '0;
`ifdef OAM_SCAN_XSORT_EN
    for (int k = 0; k < BUFFER_MAX; k++) begin
      if ((NW'(k) < n_q) && (line_q[k][17:10] <= oam_data_in)) begin
        ins_pos_c = ins_pos_c + NW'(1);
      end
    end
`else
    ins_pos_c = n_q;
`endif
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ly_d         = ly_q;
    tall_d       = tall_q;
    y_d          = y_q;
    y_ok_d       = y_ok_q;
    n_d          = n_q;
    ovf_d        = ovf_q;
    busy_d       = busy_q;
    done_d       = done_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    line_d       = line_q;

    if (tclk_in) begin
      done_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            ly_d         = LY_in;
            tall_d       = tall_sprite_mode_in;
            n_d          = '0;
            ovf_d        = 1'b0;
            busy_d       = 1'b1;
            idx_d        = '0;
            addr_d       = OAM_BASE;
            addr_valid_d = 1'b1;
            state_d      = ST_REQ_Y;
          end
        end
        ST_REQ_Y: begin
          addr_d  = OAM_BASE + 16'({idx_q, 2'b01});
          state_d = ST_REQ_X;
        end
        ST_REQ_X: begin
          y_d    = oam_data_in;
          y_ok_d = oam_data_valid_in;
          // The EVAL tclk doubles as the Y request of the next entry.
          if (last_c) begin
            addr_valid_d = 1'b0;
          end else begin
            addr_d = OAM_BASE + 16'({idx_nxt_c, 2'b00});
          end
          state_d = ST_EVAL;
        end
        ST_EVAL: begin
          if (hit_c) begin
            if (n_q < NW'(BUFFER_MAX)) begin
`ifdef OAM_SCAN_XSORT_EN
              for (int k = 1; k < BUFFER_MAX; k++) begin
                if ((NW'(k) > ins_pos_c) && (NW'(k) <= n_q)) begin
                  line_d[k] = line_q[k-1];
                end
              end
`endif
              for (int k = 0; k < BUFFER_MAX; k++) begin
                if (NW'(k) == ins_pos_c) begin
                  line_d[k] = new_entry_c;
                end
              end
              n_d = n_q + NW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (last_c) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_nxt_c;
            addr_d  = OAM_BASE + 16'({idx_nxt_c, 2'b01});
            state_d = ST_REQ_X;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      ly_q         <= '0;
      tall_q       <= 1'b0;
      y_q          <= '0;
      y_ok_q       <= 1'b0;
      n_q          <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= OAM_BASE;
      addr_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ly_q         <= ly_d;
      tall_q       <= tall_d;
      y_q          <= y_d;
      y_ok_q       <= y_ok_d;
      n_q          <= n_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
    end
  end

  // Line buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk_in) begin
    line_q <= line_d;
  end

  always_comb begin
    rd_entry_out = '0;
    for (int k = 0; k < BUFFER_MAX; k++) begin
      if (rd_idx_in == RW'(k)) begin
        rd_entry_out = line_q[k];
      end
    end
  end

  assign rd_valid_out       = (NW'(rd_idx_in) < n_q);
  assign oam_addr_out       = addr_q;
  assign oam_addr_valid_out = addr_valid_q;
  assign busy_out           = busy_q;
  assign done_out           = done_q;
  assign n_sprites_out      = n_q;
  assign overflow_out       = ovf_q;

endmodule
